// File: rtl/vec_pkg.sv
// vec_pkg: shared lane width, lane count and lane type for the vector datapath
package vec_pkg;
   localparam int VEC_WIDTH = 32;
   localparam int VEC_LANES = 4;
   typedef logic [VEC_WIDTH-1:0] lane_t;
endpackage

// File: rtl/out_lane_reg.sv
// out_lane_reg: one enable-gated lane register with synchronous active-low clear
module out_lane_reg
   import vec_pkg::*;
#(
   parameter int WIDTH = VEC_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   // clear wins over load; otherwise hold unless enabled
   always_ff @(posedge clk)
      if (!rst_n) q <= '0;
      else if (en) q <= d;
endmodule

// File: rtl/out_vector.sv
// out_vector: stages a 4-lane result vector and flags that one has been captured
module out_vector
   import vec_pkg::*;
#(
   parameter int WIDTH = VEC_WIDTH,
   parameter int LANES = VEC_LANES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             write_enable,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   input  logic [WIDTH-1:0] data3,
   input  logic [WIDTH-1:0] data4,
   output logic [WIDTH-1:0] data_out1,
   output logic [WIDTH-1:0] data_out2,
   output logic [WIDTH-1:0] data_out3,
   output logic [WIDTH-1:0] data_out4,
   output logic             out_valid
);
   logic [WIDTH-1:0] d [LANES];
   logic [WIDTH-1:0] q [LANES];
   assign d[0] = data1;
   assign d[1] = data2;
   assign d[2] = data3;
   assign d[3] = data4;
   assign data_out1 = q[0];
   assign data_out2 = q[1];
   assign data_out3 = q[2];
   assign data_out4 = q[3];
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      out_lane_reg #(.WIDTH(WIDTH)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (write_enable),
         .d     (d[i]),
         .q     (q[i])
      );
   end
   // sticky valid: set by any capture, cleared only by reset
   always_ff @(posedge clk)
      if (!rst_n) out_valid <= 1'b0;
      else if (write_enable) out_valid <= 1'b1;
endmodule

// File: tb/tb_out_vector.sv
// tb_out_vector: directed and random checks of out_vector against a behavioural model
module tb_out_vector;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        write_enable = 1'b0;
   logic [31:0] data1 = '0, data2 = '0, data3 = '0, data4 = '0;
   logic [31:0] data_out1, data_out2, data_out3, data_out4;
   logic        out_valid;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] m_out [4];
   logic        m_valid;

   out_vector dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .write_enable (write_enable),
      .data1        (data1),
      .data2        (data2),
      .data3        (data3),
      .data4        (data4),
      .data_out1    (data_out1),
      .data_out2    (data_out2),
      .data_out3    (data_out3),
      .data_out4    (data_out4),
      .out_valid    (out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
      logic [31:0] in_v [4];
      rst_n = r;
      write_enable = w;
      data1 = a;
      data2 = b;
      data3 = c;
      data4 = d;
      in_v = '{a, b, c, d};
      @(posedge clk);
      if (!r) begin
         m_out = '{default: 32'h0};
         m_valid = 1'b0;
      end else if (w) begin
         m_out = in_v;
         m_valid = 1'b1;
      end
      #1;
      chk("lane0", data_out1, m_out[0]);
      chk("lane1", data_out2, m_out[1]);
      chk("lane2", data_out3, m_out[2]);
      chk("lane3", data_out4, m_out[3]);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
   endtask

   initial begin
      m_out = '{default: 32'h0};
      m_valid = 1'b0;
      step(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom);
      step(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom);
      step(1'b1, 1'b1, 32'h4261999A, 32'h4134CCCD, 32'h423F999A, 32'h4287CCCD);
      chk("single_write_lane0", data_out1, 32'h4261999A);
      chk("single_write_lane3", data_out4, 32'h4287CCCD);
      repeat (3) step(1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
      chk("hold_lane1", data_out2, 32'h4134CCCD);
      chk("hold_lane2", data_out3, 32'h423F999A);
      step(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom);
      step(1'b1, 1'b1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
      chk("b2b_lane0", data_out1, 32'h3F800000);
      step(1'b0, 1'b1, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
      chk("rst_prio_valid", {31'd0, out_valid}, 32'd0);
      step(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom);
      step(1'b1, 1'b1, 32'h00000001, 32'h00000002, 32'h00000004, 32'h00000008);
      chk("indep_lane3", data_out4, 32'h00000008);
      for (int n = 0; n < 60; n++)
         step(($urandom_range(15) != 0), $urandom_range(1), $urandom, $urandom, $urandom, $urandom);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
